// File: rtl/bloom_query_engine.sv
// Bloom filter membership query engine: two-hash read of a shared BRAM bit-array with early exit on a clear bit.
// Optional BLOOM_QUERY_STATS_EN adds saturating query/hit counters with a clear input.
module bloom_query_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  localparam int BIT_W  = $clog2(DATA_W),
  localparam int HASH_W = ADDR_W + BIT_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [HASH_W-1:0] q_hash1,
  input  logic [HASH_W-1:0] q_hash2,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_hit,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  input  logic              wr_busy
`ifdef BLOOM_QUERY_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_queries,
  output logic [31:0]       stat_hits
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t            state;
  logic [HASH_W-1:0] hash1;
  logic [HASH_W-1:0] hash2;
  logic              idx;
  logic [1:0]        wait_cnt;
  logic [BIT_W-1:0]  cur_bit;

  assign q_ready = (state == IDLE) && !rsta;
  // The read strobe must react to wr_busy in the same cycle, so it cannot be a register.
  assign bram_en = (state == ISSUE) && !wr_busy && !rsta;
  assign cur_bit = idx ? hash2[BIT_W-1:0] : hash1[BIT_W-1:0];

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= IDLE;
      r_valid   <= 1'b0;
      r_hit     <= 1'b0;
      bram_addr <= '0;
      idx       <= 1'b0;
      hash1     <= '0;
      hash2     <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_valid) begin
            hash1     <= q_hash1;
            hash2     <= q_hash2;
            idx       <= 1'b0;
            bram_addr <= q_hash1[HASH_W-1:BIT_W];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!wr_busy) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST) begin
            if (!bram_dout[cur_bit]) begin
              r_hit   <= 1'b0;
              r_valid <= 1'b1;
              state   <= RESP;
            end else if (!idx) begin
              idx       <= 1'b1;
              bram_addr <= hash2[HASH_W-1:BIT_W];
              state     <= ISSUE;
            end else begin
              r_hit   <= 1'b1;
              r_valid <= 1'b1;
              state   <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLOOM_QUERY_STATS_EN
  // Clear takes priority over a same-cycle handshake; both counters stick at all-ones.
  always_ff @(posedge clka) begin
    if (rsta || stat_clr) begin
      stat_queries <= '0;
      stat_hits    <= '0;
    end else if (r_valid && r_ready) begin
      if (stat_queries != 32'hFFFF_FFFF) stat_queries <= stat_queries + 32'd1;
      if (r_hit && stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
    end
  end
`endif

endmodule
